// File: rtl/reset_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reset_seq_pkg                                                 |
// | Brief    : Shared types and helpers for the reset sequencer.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package reset_seq_pkg;

  // Sequencer states; encoding is visible on debug taps so it is fixed.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    PERIPH  = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  // Larger of two integers, used to size the shared down-counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bit_sync                                                      |
// | Brief    : N-stage single-bit synchroniser with a selectable reset value.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; reset fills it.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reset_sequencer                                               |
// | Brief    : Synchronises PLL ~lock, stretches it, then releases sys_reset |
// |            and periph_reset in order and raises ready.                   |
// | Options  : RESET_SEQ_LOSS_CNT_EN adds the lock_loss_count output.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 1024,
  parameter int PERIPH_DELAY   = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_reset_in,
  output logic       sys_reset,
  output logic       periph_reset,
`ifdef RESET_SEQ_LOSS_CNT_EN
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
`endif
  output logic       ready
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, PERIPH_DELAY)) + 1;
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LOAD  = CNT_W'(PERIPH_DELAY - 1);

  logic             lock_n;
  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  bit_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_lock_sync (
    .clock(clock),
    .reset(reset),
    .d    (pll_reset_in),
    .q    (lock_n)
  );

  // State, counter and reset outputs; outputs follow the next state so they
  // change on the same edge as the state register and never glitch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= HOLD;
      cnt          <= '0;
      sys_reset    <= 1'b1;
      periph_reset <= 1'b1;
      ready        <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      sys_reset    <= (state_next == HOLD) || (state_next == STRETCH);
      periph_reset <= (state_next != RUN);
      ready        <= (state_next == RUN);
    end
  end

  // Next-state and counter logic; lock loss outranks counter expiry.
  always_comb begin
    state_next = state;
    cnt_next   = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;
    case (state)
      HOLD: begin
        if (!lock_n) begin
          state_next = STRETCH;
          cnt_next   = STRETCH_LOAD;
        end
      end
      STRETCH: begin
        if (lock_n) begin
          state_next = HOLD;
        end else if (cnt == '0) begin
          state_next = PERIPH;
          cnt_next   = PERIPH_LOAD;
        end
      end
      PERIPH: begin
        if (lock_n) begin
          state_next = HOLD;
        end else if (cnt == '0) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (lock_n) begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = HOLD;
      end
    endcase
  end

`ifdef RESET_SEQ_LOSS_CNT_EN
  logic loss_evt;

  // A lock loss is any return to HOLD from an active state.
  assign loss_evt = (state != HOLD) && lock_n;

  // Saturating count of lock losses; external reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_loss_count <= '0;
    end else if (loss_evt && (lock_loss_count != {LOSS_CNT_W{1'b1}})) begin
      lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire
